// File: rtl/sram_pixel_reader.sv
// SRAM read stage: walks N two-word pixels from a base address, unpacks them onto a
// valid/ready stream and accumulates per-channel sums for downstream mean computation.
module sram_pixel_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int PIX_CNT_W  = 10,
  parameter int SUM_W      = 8 + PIX_CNT_W
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [PIX_CNT_W-1:0]  i_num_pix,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic                  o_sram_cs,
  output logic                  o_sram_we,
  output logic                  o_sram_oe,
  input  logic [DATA_WIDTH-1:0] i_sram_data,
  output logic                  o_pix_valid,
  input  logic                  i_pix_ready,
  output logic [7:0]            o_r,
  output logic [7:0]            o_g,
  output logic [7:0]            o_b,
  output logic [7:0]            o_gray,
  output logic [SUM_W-1:0]      o_sum_r,
  output logic [SUM_W-1:0]      o_sum_g,
  output logic [SUM_W-1:0]      o_sum_b,
  output logic [SUM_W-1:0]      o_sum_gray,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [2:0] {StIdle, StRd0, StRd1, StOut, StDone} state_t;

  localparam logic [ADDR_WIDTH-1:0] AddrOne = 1;
  localparam logic [PIX_CNT_W-1:0]  CntOne  = 1;

  state_t               state;
  logic [PIX_CNT_W-1:0] count;
  logic [PIX_CNT_W-1:0] num_pix;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state       <= StIdle;
      count       <= '0;
      num_pix     <= '0;
      o_sram_addr <= '0;
      o_sram_cs   <= 1'b0;
      o_sram_we   <= 1'b1;
      o_sram_oe   <= 1'b1;
      o_pix_valid <= 1'b0;
      o_r         <= '0;
      o_g         <= '0;
      o_b         <= '0;
      o_gray      <= '0;
      o_sum_r     <= '0;
      o_sum_g     <= '0;
      o_sum_b     <= '0;
      o_sum_gray  <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      // Write enable is never released; this block only reads.
      o_sram_we <= 1'b1;
      o_done    <= 1'b0;
      unique case (state)
        StIdle: begin
          if (i_start) begin
            o_sum_r    <= '0;
            o_sum_g    <= '0;
            o_sum_b    <= '0;
            o_sum_gray <= '0;
            count      <= '0;
            num_pix    <= i_num_pix;
            o_busy     <= 1'b1;
            if (i_num_pix != '0) begin
              o_sram_addr <= i_base_addr;
              o_sram_cs   <= 1'b1;
              o_sram_oe   <= 1'b0;
              state       <= StRd0;
            end else begin
              o_done <= 1'b1;
              state  <= StDone;
            end
          end
        end
        StRd0: begin
          o_r         <= i_sram_data[15:8];
          o_g         <= i_sram_data[7:0];
          o_sum_r     <= o_sum_r + SUM_W'(i_sram_data[15:8]);
          o_sum_g     <= o_sum_g + SUM_W'(i_sram_data[7:0]);
          o_sram_addr <= o_sram_addr + AddrOne;
          state       <= StRd1;
        end
        StRd1: begin
          o_b         <= i_sram_data[15:8];
          o_gray      <= i_sram_data[7:0];
          o_sum_b     <= o_sum_b + SUM_W'(i_sram_data[15:8]);
          o_sum_gray  <= o_sum_gray + SUM_W'(i_sram_data[7:0]);
          o_sram_cs   <= 1'b0;
          o_sram_oe   <= 1'b1;
          o_pix_valid <= 1'b1;
          state       <= StOut;
        end
        StOut: begin
          if (i_pix_ready) begin
            o_pix_valid <= 1'b0;
            count       <= count + CntOne;
            if (count + CntOne == num_pix) begin
              o_done <= 1'b1;
              state  <= StDone;
            end else begin
              o_sram_addr <= o_sram_addr + AddrOne;
              o_sram_cs   <= 1'b1;
              o_sram_oe   <= 1'b0;
              state       <= StRd0;
            end
          end
        end
        StDone: begin
          o_busy <= 1'b0;
          state  <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_pixel_reader.sv
// Directed bench for sram_pixel_reader with a behavioural asynchronous-read SRAM model.
module tb_sram_pixel_reader;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [9:0]  i_base_addr;
  logic [9:0]  i_num_pix;
  logic [9:0]  o_sram_addr;
  logic        o_sram_cs, o_sram_we, o_sram_oe;
  logic [15:0] i_sram_data;
  logic        o_pix_valid, i_pix_ready;
  logic [7:0]  o_r, o_g, o_b, o_gray;
  logic [17:0] o_sum_r, o_sum_g, o_sum_b, o_sum_gray;
  logic        o_busy, o_done;

  int tests = 0;
  int fails = 0;
  int we_bad = 0;
  logic [15:0] mem [0:1023];
  logic [9:0]  addr_log [$];

  always #5 clk = ~clk;

  assign i_sram_data = (o_sram_cs && o_sram_we && !o_sram_oe) ? mem[o_sram_addr] : 16'hDEAD;

  sram_pixel_reader dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_num_pix   (i_num_pix),
    .o_sram_addr (o_sram_addr),
    .o_sram_cs   (o_sram_cs),
    .o_sram_we   (o_sram_we),
    .o_sram_oe   (o_sram_oe),
    .i_sram_data (i_sram_data),
    .o_pix_valid (o_pix_valid),
    .i_pix_ready (i_pix_ready),
    .o_r         (o_r),
    .o_g         (o_g),
    .o_b         (o_b),
    .o_gray      (o_gray),
    .o_sum_r     (o_sum_r),
    .o_sum_g     (o_sum_g),
    .o_sum_b     (o_sum_b),
    .o_sum_gray  (o_sum_gray),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  // Log every address presented as an active read, and any deassertion of we.
  always @(negedge clk) begin
    if (o_sram_cs && !o_sram_oe) addr_log.push_back(o_sram_addr);
    if (o_sram_we !== 1'b1) we_bad++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_pixel(input string tag, input logic [7:0] r, input logic [7:0] g,
                             input logic [7:0] b, input logic [7:0] gy);
    check({tag, " valid"}, 32'(o_pix_valid), 1);
    check({tag, " r"}, 32'(o_r), 32'(r));
    check({tag, " g"}, 32'(o_g), 32'(g));
    check({tag, " b"}, 32'(o_b), 32'(b));
    check({tag, " gray"}, 32'(o_gray), 32'(gy));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " cs"}, 32'(o_sram_cs), 0);
    check({tag, " we"}, 32'(o_sram_we), 1);
    check({tag, " oe"}, 32'(o_sram_oe), 1);
    check({tag, " addr"}, 32'(o_sram_addr), 0);
    check({tag, " valid"}, 32'(o_pix_valid), 0);
    check({tag, " pixel"}, {o_r, o_g, o_b, o_gray}, 0);
    check({tag, " sum_r"}, 32'(o_sum_r), 0);
    check({tag, " sum_g"}, 32'(o_sum_g), 0);
    check({tag, " sum_b"}, 32'(o_sum_b), 0);
    check({tag, " sum_gray"}, 32'(o_sum_gray), 0);
    check({tag, " busy"}, 32'(o_busy), 0);
    check({tag, " done"}, 32'(o_done), 0);
  endtask

  task automatic start(input logic [9:0] base, input logic [9:0] num);
    i_start     = 1'b1;
    i_base_addr = base;
    i_num_pix   = num;
    step();
    i_start     = 1'b0;
    i_base_addr = 10'd777;
    i_num_pix   = 10'd999;
  endtask

  task automatic check_log2(input string tag, input logic [9:0] a0, input logic [9:0] a1);
    check({tag, " log size"}, 32'(addr_log.size()), 2);
    if (addr_log.size() == 2) begin
      check({tag, " log[0]"}, 32'(addr_log[0]), 32'(a0));
      check({tag, " log[1]"}, 32'(addr_log[1]), 32'(a1));
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[0]    = 16'd53467;
    mem[1]    = 16'd60352;
    mem[2]    = 16'd53980;
    mem[3]    = 16'd60583;
    mem[50]   = 16'd54866;
    mem[51]   = 16'd52359;
    mem[1023] = 16'h1234;

    i_rst = 1'b1; i_start = 1'b0; i_base_addr = '0; i_num_pix = '0; i_pix_ready = 1'b1;
    step();
    step();
    check_reset_outputs("reset");
    i_rst = 1'b0;
    step();

    // One pixel from base 0.
    addr_log.delete();
    start(10'd0, 10'd1);
    check("t1 c1 busy", 32'(o_busy), 1);
    check("t1 c1 cs", 32'(o_sram_cs), 1);
    check("t1 c1 oe", 32'(o_sram_oe), 0);
    check("t1 c1 addr", 32'(o_sram_addr), 0);
    check("t1 c1 valid", 32'(o_pix_valid), 0);
    step();
    check("t1 c2 addr", 32'(o_sram_addr), 1);
    check("t1 c2 valid", 32'(o_pix_valid), 0);
    step();
    check_pixel("t1 c3", 8'd208, 8'd219, 8'd235, 8'd192);
    check("t1 c3 cs", 32'(o_sram_cs), 0);
    check("t1 c3 done", 32'(o_done), 0);
    step();
    check("t1 c4 done", 32'(o_done), 1);
    check("t1 c4 valid", 32'(o_pix_valid), 0);
    check("t1 sum_r", 32'(o_sum_r), 208);
    check("t1 sum_gray", 32'(o_sum_gray), 192);
    step();
    check("t1 c5 done", 32'(o_done), 0);
    check("t1 c5 busy", 32'(o_busy), 0);
    check_log2("t1", 10'd0, 10'd1);

    // Two pixels back to back with ready high.
    step();
    start(10'd0, 10'd2);
    step(); step();
    check_pixel("t2 p0", 8'd208, 8'd219, 8'd235, 8'd192);
    step();
    check("t2 c4 valid", 32'(o_pix_valid), 0);
    check("t2 c4 addr", 32'(o_sram_addr), 2);
    check("t2 c4 done", 32'(o_done), 0);
    step(); step();
    check_pixel("t2 p1", 8'd210, 8'd220, 8'd236, 8'd167);
    step();
    check("t2 done", 32'(o_done), 1);
    check("t2 sum_r", 32'(o_sum_r), 418);
    check("t2 sum_g", 32'(o_sum_g), 439);
    check("t2 sum_b", 32'(o_sum_b), 471);
    check("t2 sum_gray", 32'(o_sum_gray), 359);
    step(); step(); step();
    check("t2 hold sum_r", 32'(o_sum_r), 418);
    check("t2 hold sum_gray", 32'(o_sum_gray), 359);

    // Non-zero base address.
    addr_log.delete();
    start(10'd50, 10'd1);
    check("t3 c1 addr", 32'(o_sram_addr), 50);
    step(); step();
    check_pixel("t3", 8'd214, 8'd82, 8'd204, 8'd135);
    step();
    check("t3 done", 32'(o_done), 1);
    check("t3 sum_g", 32'(o_sum_g), 82);
    check_log2("t3", 10'd50, 10'd51);

    // Consumer stall for five cycles in OUT.
    step();
    addr_log.delete();
    i_pix_ready = 1'b0;
    start(10'd50, 10'd1);
    step(); step();
    for (int k = 0; k < 5; k++) begin
      check_pixel("t4 stall", 8'd214, 8'd82, 8'd204, 8'd135);
      check("t4 stall cs", 32'(o_sram_cs), 0);
      check("t4 stall addr", 32'(o_sram_addr), 51);
      check("t4 stall done", 32'(o_done), 0);
      step();
    end
    i_pix_ready = 1'b1;
    check("t4 still valid", 32'(o_pix_valid), 1);
    step();
    check("t4 done", 32'(o_done), 1);
    check("t4 valid", 32'(o_pix_valid), 0);
    check_log2("t4", 10'd50, 10'd51);

    // Zero-length run.
    step();
    addr_log.delete();
    start(10'd3, 10'd0);
    check("t5 done", 32'(o_done), 1);
    check("t5 busy", 32'(o_busy), 1);
    check("t5 cs", 32'(o_sram_cs), 0);
    check("t5 sum_r", 32'(o_sum_r), 0);
    check("t5 sum_b", 32'(o_sum_b), 0);
    step();
    check("t5 done low", 32'(o_done), 0);
    check("t5 busy low", 32'(o_busy), 0);
    check("t5 log size", 32'(addr_log.size()), 0);

    // Reset mid-RD1, with an ignored start while busy.
    step();
    start(10'd1023, 10'd1);
    check("t6 c1 addr", 32'(o_sram_addr), 1023);
    i_start = 1'b1; i_base_addr = 10'd5; i_num_pix = 10'd7;
    step();
    i_start = 1'b0;
    check("t6 c2 wrap addr", 32'(o_sram_addr), 0);
    check("t6 c2 r", 32'(o_r), 8'h12);
    i_rst = 1'b1;
    step();
    check_reset_outputs("t6 midrun reset");
    i_rst = 1'b0;
    step();

    // Full wrap-around run with an ignored start.
    addr_log.delete();
    start(10'd1023, 10'd1);
    i_start = 1'b1; i_base_addr = 10'd5; i_num_pix = 10'd7;
    step();
    i_start = 1'b0;
    check("t7 c2 addr", 32'(o_sram_addr), 0);
    step();
    check_pixel("t7", 8'h12, 8'h34, 8'd208, 8'd219);
    step();
    check("t7 done", 32'(o_done), 1);
    check("t7 sum_b", 32'(o_sum_b), 208);
    step();
    check("t7 busy low", 32'(o_busy), 0);
    check("t7 cs", 32'(o_sram_cs), 0);
    check_log2("t7", 10'd1023, 10'd0);
    check("we never low", 32'(we_bad), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
